// File: rtl/behave_adder.sv
// behave_adder: registered unsigned add/subtract with carry/borrow, sticky
// carry flag and saturating accepted-operation counter. One-cycle latency.
// Optional build macro BEHAVE_ADDER_SAT_EN: add results clamp to all ones on
// carry, subtract results clamp to zero on borrow.
module behave_adder #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             sub,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  output logic             carry_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [EXT_W-1:0] raw_c;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;

  // Arithmetic core: bit WIDTH of the extended result is carry (add) or borrow (sub)
  always_comb begin
    raw_c = '0;
    res_c = '0;
    cy_c  = 1'b0;
    if (sub) begin
      raw_c = EXT_W'({1'b0, a}) - EXT_W'({1'b0, b});
    end else begin
      raw_c = EXT_W'({1'b0, a}) + EXT_W'({1'b0, b});
    end
    cy_c  = raw_c[WIDTH];
    res_c = raw_c[WIDTH-1:0];
`ifdef BEHAVE_ADDER_SAT_EN
    if (cy_c) begin
      res_c = sub ? '0 : {WIDTH{1'b1}};
    end
`endif
  end

  // Next-state: result hold/load, clear-then-apply for flags and counter
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    sticky_d    = clr_flags ? 1'b0 : sticky_q;
    cnt_d       = clr_flags ? '0 : cnt_q;
    if (in_valid) begin
      sum_d       = res_c;
      carry_d     = cy_c;
      out_valid_d = 1'b1;
      sticky_d    = sticky_d | cy_c;
      if (cnt_d != CNT_MAX) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sum          = sum_q;
  assign carry        = carry_q;
  assign out_valid    = out_valid_q;
  assign carry_sticky = sticky_q;
  assign op_count     = cnt_q;

endmodule

// File: tb/tb_behave_adder.sv
// Self-checking bench for behave_adder against an integer-arithmetic model.
module tb_behave_adder;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int MODV    = 1 << WIDTH;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_valid = 1'b0;
  logic             sub = 1'b0;
  logic             clr_flags = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;
  logic             carry_sticky;
  logic [CNT_W-1:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int m_sum = 0, m_carry = 0, m_ov = 0, m_sticky = 0, m_cnt = 0;

  behave_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .sub(sub),
    .clr_flags(clr_flags), .sum(sum), .carry(carry), .out_valid(out_valid),
    .carry_sticky(carry_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model one rising edge from the specification's arithmetic rules
  task automatic model_edge(input int ia, input int ib, input bit v, input bit s,
                            input bit clr, input bit r);
    int c, res;
    if (r) begin
      m_sum = 0; m_carry = 0; m_ov = 0; m_sticky = 0; m_cnt = 0;
      return;
    end
    c = 0;
    res = m_sum;
    if (v) begin
      if (!s) begin
        c   = (ia + ib >= MODV) ? 1 : 0;
        res = (ia + ib) % MODV;
`ifdef BEHAVE_ADDER_SAT_EN
        if (c == 1) res = MODV - 1;
`endif
      end else begin
        c   = (ia < ib) ? 1 : 0;
        res = (ia - ib + MODV) % MODV;
`ifdef BEHAVE_ADDER_SAT_EN
        if (c == 1) res = 0;
`endif
      end
    end
    if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    if (v) begin
      m_sum = res;
      m_carry = c;
      m_sticky = m_sticky | c;
      if (m_cnt < CNT_TOP) m_cnt++;
    end
    m_ov = v ? 1 : 0;
  endtask

  // Drive one cycle, advance the model and compare all outputs
  task automatic step(input int ia, input int ib, input bit v, input bit s,
                      input bit clr, input bit r, input bit chk_all);
    a = WIDTH'(ia); b = WIDTH'(ib); in_valid = v; sub = s;
    clr_flags = clr; rst = r;
    @(posedge clk);
    model_edge(ia, ib, v, s, clr, r);
    #1;
    check_eq("sum", int'(sum), m_sum);
    check_eq("carry", int'(carry), m_carry);
    check_eq("out_valid", int'(out_valid), m_ov);
    if (chk_all) begin
      check_eq("carry_sticky", int'(carry_sticky), m_sticky);
      check_eq("op_count", int'(op_count), m_cnt);
    end
  endtask

  initial begin
    // Reset for two cycles
    step(0, 0, 1, 0, 1, 1, 1);
    step(3, 3, 1, 0, 0, 1, 1);
    check_eq("rst_sum_const", int'(sum), 0);
    check_eq("rst_cnt_const", int'(op_count), 0);

    // Basic add sequence
    step(1, 0, 1, 0, 0, 0, 1);
    check_eq("add1_sum", int'(sum), 1);
    step(2, 0, 1, 0, 0, 0, 1);
    check_eq("add2_sum", int'(sum), 2);
    step(2, 3, 1, 0, 0, 0, 1);
    check_eq("add3_carry", int'(carry), 1);
    check_eq("add3_sticky", int'(carry_sticky), 1);
    check_eq("add3_cnt", int'(op_count), 3);
    step(0, 0, 0, 0, 0, 0, 1);

    // Wrap / saturate on 3+3
    step(3, 3, 1, 0, 0, 0, 1);
`ifdef BEHAVE_ADDER_SAT_EN
    check_eq("add33_sum", int'(sum), 3);
`else
    check_eq("add33_sum", int'(sum), 2);
`endif

    // Subtract
    step(1, 3, 1, 1, 0, 0, 1);
`ifdef BEHAVE_ADDER_SAT_EN
    check_eq("sub13_sum", int'(sum), 0);
`else
    check_eq("sub13_sum", int'(sum), 2);
`endif
    check_eq("sub13_borrow", int'(carry), 1);
    step(3, 1, 1, 1, 0, 0, 1);
    check_eq("sub31_sum", int'(sum), 2);
    check_eq("sub31_borrow", int'(carry), 0);

    // Clear alone, then clear colliding with an accept
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("clr_cnt", int'(op_count), 0);
    step(1, 0, 1, 0, 1, 0, 1);
    check_eq("clracc_cnt", int'(op_count), 1);
    check_eq("clracc_sticky", int'(carry_sticky), 0);

    // Clear colliding with a carrying accept
    step(3, 2, 1, 0, 1, 0, 1);
    check_eq("clrcy_sticky", int'(carry_sticky), 1);

    // Hold while operands toggle
    for (int i = 0; i < 50; i++) begin
      step(int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)),
           0, i[0], 0, 0, 1);
    end

    // Saturating counter
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)),
           1, $urandom_range(0, 1) == 1, 0, 0, (i % 10 == 0) || (i > 250));
    end
    check_eq("cnt_sat", int'(op_count), CNT_TOP);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, 1);
    end

    // Reset coincident with a carrying accept
    step(3, 3, 1, 0, 0, 0, 1);
    step(3, 3, 1, 0, 0, 1, 1);
    check_eq("rstacc_ov", int'(out_valid), 0);
    check_eq("rstacc_carry", int'(carry), 0);
    check_eq("rstacc_cnt", int'(op_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
